vga_fb_arbiter: RTL and testbench

- Arbitrates one single-port framebuffer RAM between the VGA scan-out reader and NREQ game-engine pixel writers.
- Sits between the VGA driver's pixel fetch path (x/y already converted to a linear address upstream) and the framebuffer RAM.
- Scan-out reads have absolute priority so the display never tears.
- Writers share the remaining memory slots round-robin.

---
 rtl/vga_fb_arbiter.sv | 173 +++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: VGA scan-out reads win every slot they ask for, and
// writers share the remaining slots round-robin. Optional range check under FB_ADDR_CHECK_EN.
module vga_fb_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned AW       = 19,
   parameter int unsigned DW       = 8,
   parameter int unsigned FB_WORDS = 307200
) (
   input  logic               real100clock,
   input  logic               resetn,
   input  logic               pix_req,
   input  logic [AW-1:0]      pix_addr,
   output logic               pix_valid,
   output logic [DW-1:0]      pix_data,
   input  logic [NREQ-1:0]    wr_req,
   input  logic [NREQ*AW-1:0] wr_addr,
   input  logic [NREQ*DW-1:0] wr_data,
   output logic [NREQ-1:0]    wr_gnt,
   output logic               mem_en,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   input  logic [DW-1:0]      mem_rdata
`ifdef FB_ADDR_CHECK_EN
   ,
   output logic [15:0]        err_cnt
`endif
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [AW:0] FbWordsW = (AW + 1)'(FB_WORDS);

   typedef enum logic [1:0] {CmdIdle, CmdRead, CmdWrite} cmd_e;

   cmd_e            cmd;
   logic [NREQ-1:0] elig;
   logic            sel_found, hi_found;
   logic [PW-1:0]   sel_idx, hi_idx, lo_idx;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   logic            pix_valid_q, pix_valid_d;
   logic [DW-1:0]   pix_data_q, pix_data_d;
   logic            rd1_q, rd1_d, rd2_q;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            en_q, en_d, we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [15:0]     err_q, err_d;

   // A writer sees its grant one cycle before it can drop wr_req; mask it so it is not re-granted.
   assign elig = wr_req & ~gnt_q;

   // Lowest eligible index at/after the pointer wins, otherwise lowest eligible overall (wrap).
   always_comb begin
      hi_found  = 1'b0;
      hi_idx    = '0;
      lo_idx    = '0;
      sel_found = 1'b0;
      for (int i = int'(NREQ) - 1; i >= 0; i--) begin
         if (elig[i]) begin
            sel_found = 1'b1;
            lo_idx    = PW'(i);
            if (PW'(i) >= ptr_q) begin
               hi_found = 1'b1;
               hi_idx   = PW'(i);
            end
         end
      end
      sel_idx = hi_found ? hi_idx : lo_idx;
   end

   assign sel_addr = wr_addr[32'(sel_idx) * AW +: AW];
   assign sel_data = wr_data[32'(sel_idx) * DW +: DW];

   always_comb begin
      cmd = CmdIdle;
      if (pix_req) begin
         cmd = CmdRead;
      end else if (sel_found) begin
         cmd = CmdWrite;
      end
   end

   always_comb begin
      en_d    = 1'b0;
      we_d    = 1'b0;
      rd1_d   = 1'b0;
      gnt_d   = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ptr_d   = ptr_q;
      err_d   = err_q;
      unique case (cmd)
         CmdRead: begin
            en_d   = 1'b1;
            rd1_d  = 1'b1;
            addr_d = pix_addr;
         end
         CmdWrite: begin
            gnt_d[sel_idx] = 1'b1;
            ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
`ifdef FB_ADDR_CHECK_EN
            if ({1'b0, sel_addr} >= FbWordsW) begin
               err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
            end else begin
               en_d    = 1'b1;
               we_d    = 1'b1;
               addr_d  = sel_addr;
               wdata_d = sel_data;
            end
`else
            en_d    = 1'b1;
            we_d    = 1'b1;
            addr_d  = sel_addr;
            wdata_d = sel_data;
`endif
         end
         default: ;
      endcase
   end

   // rd1: RAM read cycle, rd2: mem_rdata valid, then captured into pix_data.
   always_comb begin
      pix_valid_d = rd2_q;
      pix_data_d  = rd2_q ? mem_rdata : pix_data_q;
   end

   always_ff @(posedge real100clock or negedge resetn) begin
      if (!resetn) begin
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         rd1_q       <= 1'b0;
         rd2_q       <= 1'b0;
         gnt_q       <= '0;
         en_q        <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ptr_q       <= '0;
         err_q       <= '0;
      end else begin
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         rd1_q       <= rd1_d;
         rd2_q       <= rd1_q;
         gnt_q       <= gnt_d;
         en_q        <= en_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ptr_q       <= ptr_d;
         err_q       <= err_d;
      end
   end

   assign pix_valid = pix_valid_q;
   assign pix_data  = pix_data_q;
   assign wr_gnt    = gnt_q;
   assign mem_en    = en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

`ifdef FB_ADDR_CHECK_EN
   assign err_cnt = err_q;
`else
   logic unused_range_check;
   assign unused_range_check = ^{FbWordsW, err_q};
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed steps plus randomized traffic against a slot-level
// reference model (priority, round-robin, 3-cycle read latency, RAM contents).
module tb_vga_fb_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned AW = 19;
   localparam int unsigned DW = 8;
   localparam int unsigned FB_WORDS = 307200;

   logic                clk, resetn;
   logic                pix_req;
   logic [AW-1:0]       pix_addr;
   logic                pix_valid;
   logic [DW-1:0]       pix_data;
   logic [NREQ-1:0]     wr_req;
   logic [NREQ*AW-1:0]  wr_addr;
   logic [NREQ*DW-1:0]  wr_data;
   logic [NREQ-1:0]     wr_gnt;
   logic                mem_en, mem_we;
   logic [AW-1:0]       mem_addr;
   logic [DW-1:0]       mem_wdata, mem_rdata;
   logic [15:0]         err_cnt;

   vga_fb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .FB_WORDS(FB_WORDS)) dut (
      .real100clock(clk), .resetn(resetn),
      .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid), .pix_data(pix_data),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef FB_ADDR_CHECK_EN
      , .err_cnt(err_cnt)
`endif
   );

`ifndef FB_ADDR_CHECK_EN
   assign err_cnt = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Bench RAM: unwritten words read back as addr[7:0].
   logic [DW-1:0] ram [logic [AW-1:0]];
   initial mem_rdata = '0;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] = mem_wdata;
         else mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : mem_addr[7:0];
      end
   end

   int tests = 0, fails = 0;
   int cyc = 0;

   // Writer agents
   logic [NREQ-1:0] w_req, w_done;
   logic [AW-1:0]   w_addr [NREQ];
   logic [DW-1:0]   w_data [NREQ];
   int              w_start [NREQ];
   bit              fair_on;
   int              max_wait;

   // Reference model state
   logic [DW-1:0]   ref_mem [logic [AW-1:0]];
   int              ptr;
   logic [NREQ-1:0] exp_gnt;
   logic            exp_en, exp_we, addr_known;
   logic [AW-1:0]   exp_addr;
   logic [DW-1:0]   exp_wdata, exp_pd;
   logic [15:0]     exp_err;
   int              due_q [$];
   logic [DW-1:0]   dat_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a[7:0];
   endfunction

   function automatic logic [AW-1:0] gen_addr();
      if ($urandom_range(3) == 0) return AW'(FB_WORDS - 10 + $urandom_range(19));
      return AW'(32'h200 + $urandom_range(31));
   endfunction

   task automatic model_reset();
      ptr = 0; exp_gnt = '0; exp_en = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
      addr_known = 1; exp_pd = '0; exp_err = '0;
      due_q.delete(); dat_q.delete();
   endtask

   // Decide the command presented in the next cycle from this cycle's inputs.
   task automatic model_step();
      logic [NREQ-1:0] elig;
      logic [AW-1:0] a;
      int k;
      bit found;
      elig = wr_req & ~exp_gnt;
      exp_gnt = '0; exp_en = 0; exp_we = 0;
      if (pix_req) begin
         exp_en = 1; exp_addr = pix_addr; addr_known = 1;
         due_q.push_back(cyc + 3);
         dat_q.push_back(ref_rd(pix_addr));
      end else if (elig != '0) begin
         found = 0; k = 0;
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!found && elig[(ptr + j) % int'(NREQ)]) begin
               found = 1; k = (ptr + j) % int'(NREQ);
            end
         end
         exp_gnt[k] = 1'b1;
         ptr = (k + 1) % int'(NREQ);
         a = wr_addr[k*AW +: AW];
`ifdef FB_ADDR_CHECK_EN
         if (a >= AW'(FB_WORDS)) begin
            if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            addr_known = 0;
         end else begin
`else
         begin
`endif
            exp_en = 1; exp_we = 1; exp_addr = a; exp_wdata = wr_data[k*DW +: DW];
            addr_known = 1;
            ref_mem[a] = exp_wdata;
         end
      end
   endtask

   task automatic check_outputs();
      logic exp_valid;
      chk("wr_gnt", 32'(wr_gnt), 32'(exp_gnt));
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (addr_known) chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
      if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      exp_valid = (due_q.size() > 0) && (due_q[0] == cyc);
      chk("pix_valid", 32'(pix_valid), 32'(exp_valid));
      if (exp_valid) begin
         exp_pd = dat_q[0];
         void'(due_q.pop_front());
         void'(dat_q.pop_front());
      end
      chk("pix_data", 32'(pix_data), 32'(exp_pd));
`ifdef FB_ADDR_CHECK_EN
      chk("err_cnt", 32'(err_cnt), 32'(exp_err));
`endif
      for (int i = 0; i < int'(NREQ); i++) begin
         if (fair_on && w_req[i] && !w_done[i] && (cyc - w_start[i]) > max_wait)
            max_wait = cyc - w_start[i];
         if (exp_gnt[i]) w_done[i] = 1'b1;
      end
   endtask

   task automatic step();
      wr_req = w_req;
      for (int i = 0; i < int'(NREQ); i++) begin
         wr_addr[i*AW +: AW] = w_addr[i];
         wr_data[i*DW +: DW] = w_data[i];
      end
      model_step();
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
   endtask

   // Granted writers drop for one cycle; idle writers may start; pending ones may withdraw.
   task automatic drive_writers(input int p_new, input int p_wd);
      for (int i = 0; i < int'(NREQ); i++) begin
         if (w_done[i]) begin
            w_req[i] = 0; w_done[i] = 0;
         end else if (!w_req[i]) begin
            if ($urandom_range(99) < p_new) begin
               w_req[i] = 1; w_addr[i] = gen_addr(); w_data[i] = DW'($urandom);
               w_start[i] = cyc;
            end
         end else if ($urandom_range(99) < p_wd) begin
            w_req[i] = 0;
         end
      end
   endtask

   task automatic clear_writers();
      w_req = '0; w_done = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
      chk({tag, "_pix_data"}, 32'(pix_data), 32'd0);
      chk({tag, "_wr_gnt"}, 32'(wr_gnt), 32'd0);
      chk({tag, "_mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   logic [NREQ-1:0] rr_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
   bit last_req;

   initial begin
      resetn = 0; pix_req = 0; pix_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0;
      fair_on = 0; max_wait = 0;
      clear_writers();
      for (int i = 0; i < int'(NREQ); i++) begin
         w_addr[i] = '0; w_data[i] = '0; w_start[i] = 0;
      end
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      resetn = 1;

      // Read latency: request at 0x100, data (addr[7:0] = 0x00) exactly 3 cycles later.
      pix_req = 1; pix_addr = 19'h00100;
      step();
      chk("rd_cmd_addr", 32'(mem_addr), 32'h00100);
      chk("rd_cmd_we", 32'(mem_we), 32'd0);
      pix_req = 0;
      step(); step();
      chk("rd_valid_e3", 32'(pix_valid), 32'd1);
      chk("rd_data_e3", 32'(pix_data), 32'h00);
      step();
      chk("rd_valid_e4", 32'(pix_valid), 32'd0);

      // Round-robin with all four requests held.
      for (int i = 0; i < int'(NREQ); i++) begin
         w_addr[i] = AW'(32'h210 + i); w_data[i] = DW'(8'hA0 + i);
      end
      w_req = '1;
      for (int n = 0; n < 5; n++) begin
         step();
         chk("rr_seq", 32'(wr_gnt), 32'(rr_seq[n]));
      end
      clear_writers();
      step(); step();

`ifdef FB_ADDR_CHECK_EN
      // Out-of-range write is granted but never reaches the RAM.
      w_addr[1] = AW'(FB_WORDS); w_data[1] = 8'h77; w_req = 4'b0010;
      step();
      chk("oob_gnt", 32'(wr_gnt), 32'b0010);
      chk("oob_en", 32'(mem_en), 32'd0);
      chk("oob_err", 32'(err_cnt), 32'd1);
      clear_writers();
      step();
      w_addr[1] = AW'(FB_WORDS - 1); w_req = 4'b0010;
      step();
      chk("last_word_en", 32'(mem_en), 32'd1);
      chk("last_word_err", 32'(err_cnt), 32'd1);
      clear_writers();
      step();
`endif

      // Read beats a simultaneous write; write follows next cycle.
      pix_req = 1; pix_addr = 19'h00205;
      w_addr[2] = 19'h00215; w_data[2] = 8'h5A; w_req = 4'b0100;
      step();
      chk("prio_no_gnt", 32'(wr_gnt), 32'd0);
      pix_req = 0;
      step();
      chk("prio_gnt", 32'(wr_gnt), 32'b0100);
      chk("prio_wdata", 32'(mem_wdata), 32'h5A);
      clear_writers();
      repeat (3) step();

      // Back-to-back reads: both served in order, writers stall.
      for (int i = 0; i < int'(NREQ); i++) begin
         w_addr[i] = gen_addr(); w_data[i] = DW'($urandom);
      end
      w_req = '1;
      pix_req = 1; pix_addr = 19'h00215;
      step();
      pix_addr = 19'h00100;
      step();
      chk("b2b_no_gnt", 32'(wr_gnt), 32'd0);
      pix_req = 0;
      repeat (4) step();
      clear_writers();
      repeat (4) step();

      // Loaded fairness: reads at maximum rate, writers busy.
      fair_on = 1; max_wait = 0;
      for (int n = 0; n < 1000; n++) begin
         pix_req = (n % 2 == 0); pix_addr = gen_addr();
         drive_writers(80, 0);
         step();
      end
      fair_on = 0;
      chk("fair_max_wait_le_8", 32'(max_wait <= 2 * int'(NREQ)), 32'd1);
      pix_req = 0;
      clear_writers();
      repeat (4) step();

      // Random traffic with withdrawals.
      last_req = 0;
      for (int n = 0; n < 1000; n++) begin
         pix_req = !last_req && ($urandom_range(99) < 40);
         last_req = pix_req;
         pix_addr = gen_addr();
         drive_writers(50, 5);
         step();
      end

      // Asynchronous reset with a read in flight.
      clear_writers();
      pix_req = 1; pix_addr = 19'h00203;
      step();
      pix_req = 0;
      #2;
      resetn = 0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      cyc++;
      #1;
      resetn = 1;
      repeat (5) step();
      for (int i = 0; i < int'(NREQ); i++) begin
         w_addr[i] = AW'(32'h208 + i); w_data[i] = DW'(8'h30 + i);
      end
      w_req = '1;
      step();
      chk("rst_first_gnt", 32'(wr_gnt), 32'b0001);
      clear_writers();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
